// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples SCLK/CS_n/MOSI in the clk domain and deserialises
// MSB-first {address, data} frames into a one-deep valid/ready holding register.
module spi_slave_rx #(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [7:0]           err_count
);

    localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_rise_p1, cs_fall_p1, cs_rise_p1, mosi_p1;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   long_flag;
    logic [FRAME_BITS-1:0]  shreg;

    logic frame_end, frame_good, frame_bad, pop, drop;

    // Stage p0: synchronisers. CS_n resets low so a select already active at
    // reset release is not mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_data};
        end
    end

    // Stage p1: registered edge pulses, with MOSI delayed to stay aligned to SCLK rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q       <= 1'b0;
            cs_q         <= 1'b0;
            sclk_rise_p1 <= 1'b0;
            cs_fall_p1   <= 1'b0;
            cs_rise_p1   <= 1'b0;
            mosi_p1      <= 1'b0;
        end else begin
            sclk_q       <= sclk_sync[SYNC_STAGES-1];
            cs_q         <= cs_sync[SYNC_STAGES-1];
            sclk_rise_p1 <= sclk_sync[SYNC_STAGES-1] & ~sclk_q;
            cs_fall_p1   <= ~cs_sync[SYNC_STAGES-1] & cs_q;
            cs_rise_p1   <= cs_sync[SYNC_STAGES-1] & ~cs_q;
            mosi_p1      <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign frame_end  = (state == SHIFT) && cs_rise_p1;
    assign frame_good = frame_end && (bit_cnt == FRAME_CNT) && !long_flag;
    assign frame_bad  = frame_end && !frame_good;
    assign pop        = out_valid && out_ready;
    assign drop       = frame_good && out_valid && !out_ready;
    assign busy       = (state == SHIFT);

    // Stage p2: frame FSM; an SCLK rise coinciding with CS_n rise is discarded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            long_flag <= 1'b0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall_p1) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        long_flag <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise_p1) begin
                        state <= IDLE;
                    end else if (sclk_rise_p1) begin
                        if (bit_cnt < FRAME_CNT) begin
                            shreg   <= {shreg[FRAME_BITS-2:0], mosi_p1};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            long_flag <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p3: holding register and error reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            if (frame_good && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_addr  <= shreg[FRAME_BITS-1:DATA_BITS];
                out_data  <= shreg[DATA_BITS-1:0];
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            frame_err <= frame_bad;
            overrun   <= drop;
            if (frame_bad || drop)
                err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: bit-level SPI master plus a frame-level
// reference model of the holding register, error pulses and error counter.
module tb_spi_slave_rx;

    localparam int AB = 8;
    localparam int DB = 32;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          spi_sclk, spi_cs_n, spi_data;
    logic          out_valid, out_ready;
    logic [AB-1:0] out_addr;
    logic [DB-1:0] out_data;
    logic          busy, frame_err, overrun;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    spi_slave_rx #(.ADDR_BITS(AB), .DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_data(spi_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .err_count(err_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observed activity, gathered on the falling edge
    logic [39:0] got_q[$];
    int          ferr_seen = 0, ovr_seen = 0, valid_cycles = 0, hold_bad = 0;
    logic        prev_valid = 1'b0, prev_pop = 1'b0;
    logic [39:0] prev_frame = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) ferr_seen <= ferr_seen + 1;
            if (overrun)   ovr_seen  <= ovr_seen + 1;
            if (out_valid) valid_cycles <= valid_cycles + 1;
            if (prev_valid && !prev_pop && out_valid && ({out_addr, out_data} !== prev_frame))
                hold_bad <= hold_bad + 1;
            if (out_valid && out_ready) got_q.push_back({out_addr, out_data});
            prev_valid <= out_valid;
            prev_pop   <= out_valid && out_ready;
            prev_frame <= {out_addr, out_data};
        end else begin
            prev_valid <= 1'b0;
            prev_pop   <= 1'b0;
        end
    end

    // Reference model: frame-level view of the receiver
    logic        mdl_valid;
    logic [39:0] mdl_frame;
    int          mdl_err, exp_ferr, exp_ovr;
    logic [39:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bump_err();
        if (mdl_err < 255) mdl_err++;
    endtask

    task automatic set_ready(input logic r);
        out_ready = r;
        if (r && mdl_valid) begin
            exp_q.push_back(mdl_frame);
            mdl_valid = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [39:0] v, input int n);
        if (n != 40) begin
            exp_ferr++;
            bump_err();
        end else if (mdl_valid && !out_ready) begin
            exp_ovr++;
            bump_err();
        end else if (out_ready) begin
            exp_q.push_back(v);
            mdl_valid = 1'b0;
        end else begin
            mdl_valid = 1'b1;
            mdl_frame = v;
        end
    endtask

    task automatic clock_bit(input logic b, input int hp);
        spi_data = b;
        repeat (hp) tick();
        spi_sclk = 1'b1;
        repeat (hp) tick();
        spi_sclk = 1'b0;
    endtask

    task automatic send(input logic [63:0] v, input int n, input int hp, input bit end_it);
        spi_cs_n = 1'b0;
        repeat (hp) tick();
        for (int i = n - 1; i >= 0; i--) clock_bit(v[i], hp);
        repeat (hp) tick();
        if (n > 0) chk("busy_in_frame", 64'(busy), 64'd1);
        if (end_it) begin
            spi_cs_n = 1'b1;
            model_frame(v[39:0], n);
        end
    endtask

    task automatic settle();
        repeat (SS + 8) tick();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(mdl_valid));
        if (mdl_valid) chk({tag, "_frame"}, 64'({out_addr, out_data}), 64'(mdl_frame));
        chk({tag, "_err_count"}, 64'(err_count), 64'(mdl_err));
        chk({tag, "_frame_err_pulses"}, 64'(ferr_seen), 64'(exp_ferr));
        chk({tag, "_overrun_pulses"}, 64'(ovr_seen), 64'(exp_ovr));
        chk({tag, "_delivered"}, 64'(got_q.size()), 64'(exp_q.size()));
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          vc0, sel, n, hp;
        logic [63:0] v;

        reset_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_data = 1'b0; out_ready = 1'b1;
        mdl_valid = 1'b0; mdl_frame = '0; mdl_err = 0; exp_ferr = 0; exp_ovr = 0;
        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out", 64'({out_addr, out_data}), 64'd0);
        chk("rst_pulses", 64'({frame_err, overrun}), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        reset_n = 1'b1;
        repeat (4) tick();

        // Single good frame with consumer always ready
        vc0 = valid_cycles;
        send(64'hA5DEADBEEF, 40, 4, 1'b1);
        settle();
        check_state("t1");
        chk("t1_valid_cycles", 64'(valid_cycles - vc0), 64'd1);
        chk("t1_rx", 64'(got_q[got_q.size() - 1]), 64'hA5DEADBEEF);

        // Overrun while the holding register is full
        set_ready(1'b0);
        send(64'h0100000001, 40, 3, 1'b1);
        settle();
        send(64'h0200000002, 40, 3, 1'b1);
        settle();
        check_state("t2");
        chk("t2_held", 64'({out_addr, out_data}), 64'h0100000001);
        set_ready(1'b1);
        settle();
        check_state("t2_drain");

        // Short and long frames, then a good one
        send(64'h12_3456_789A, 39, 3, 1'b1);
        settle();
        send(64'h1_2345_6789_AB, 41, 3, 1'b1);
        settle();
        check_state("t3_bad");
        send(64'h7F12345678, 40, 3, 1'b1);
        settle();
        check_state("t3_good");
        chk("t3_rx", 64'(got_q[got_q.size() - 1]), 64'h7F12345678);

        // Pop and commit in the same cycle: CS_n first sampled high at edge k, commit at k+3
        set_ready(1'b0);
        send(64'h1111111111, 40, 3, 1'b1);
        settle();
        send(64'h3300000033, 40, 3, 1'b0);
        spi_cs_n = 1'b1;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_frame", 64'({out_addr, out_data}), 64'h3300000033);
        out_ready = 1'b0;
        exp_q.push_back(40'h1111111111);
        mdl_valid = 1'b1;
        mdl_frame = 40'h3300000033;
        settle();
        check_state("t4");

        // Randomised frames, lengths and consumer readiness
        for (int f = 0; f < 30; f++) begin
            set_ready(1'($urandom_range(0, 1)));
            sel = $urandom_range(0, 9);
            n = (sel < 7) ? 40 : (sel == 7) ? 39 : (sel == 8) ? 41 : $urandom_range(1, 45);
            hp = $urandom_range(2, 5);
            v = {$urandom, $urandom};
            send(v, n, hp, 1'b1);
            settle();
            check_state("rand");
        end

        // SCLK activity with CS_n high must be ignored
        set_ready(1'b1);
        settle();
        for (int i = 0; i < 10; i++) begin
            spi_data = 1'($urandom_range(0, 1));
            spi_sclk = 1'b1;
            repeat (3) tick();
            spi_sclk = 1'b0;
            repeat (3) tick();
        end
        settle();
        check_state("idle_sclk");

        // Reset in the middle of a frame
        spi_cs_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 20; i++) clock_bit(1'($urandom_range(0, 1)), 3);
        chk("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        repeat (2) tick();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out", 64'({out_addr, out_data}), 64'd0);
        chk("mid_rst_pulses", 64'({frame_err, overrun}), 64'd0);
        chk("mid_rst_err_count", 64'(err_count), 64'd0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        mdl_valid = 1'b0;
        mdl_err = 0;
        reset_n = 1'b1;
        repeat (SS + 4) tick();
        send(64'h5AFFFFFFFF, 40, 3, 1'b1);
        settle();
        check_state("post_rst");
        chk("post_rst_rx", 64'(got_q[got_q.size() - 1]), 64'h5AFFFFFFFF);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send(64'($urandom_range(0, 1)), 1, 2, 1'b1);
            settle();
        end
        check_state("sat");
        chk("sat_err_count", 64'(err_count), 64'd255);

        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk("rx_order", 64'(got_q[i]), 64'(exp_q[i]));
        chk("hold_stable", 64'(hold_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
